// File: rtl/smult_pkg.sv
// Shared configuration, derived widths and FSM encoding for the round-robin multiplier scheduler.
// The scheduler is configured here; changing a value below reconfigures every file that imports it.
package smult_pkg;

  localparam int N_REQ   = 4;
  localparam int WI1     = 4;
  localparam int WF1     = 3;
  localparam int WI2     = 2;
  localparam int WF2     = 5;
  localparam int WIO     = 4;
  localparam int WFO     = 15;
  localparam int MUL_LAT = 2;

  localparam int W1    = WI1 + WF1;
  localparam int W2    = WI2 + WF2;
  localparam int WO    = WIO + WFO;
  localparam int LAT   = MUL_LAT + 1;
  localparam int CNT_W = $clog2(LAT + 2);
  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/smult_rr_sched_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
// gnt is one-hot (or zero when en is low or nobody requests); gnt_idx is its index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic          found;
  logic [IW:0]   cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = (IW+1)'(ptr) + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (en && !found && req[cand[IW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
    if (found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/smult_rr_sched.sv
// Round-robin scheduler feeding one shared pipelined multiplier; a tag pipe matched to the
// multiplier latency routes each product back to its requester, and pause drains the pipe.
module smult_rr_sched
  import smult_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W1-1:0]  req_in1,
  input  logic [N_REQ*W2-1:0]  req_in2,
  input  logic                 pause,
  output logic                 paused,
  output logic                 mul_rst_n,
  output logic [W1-1:0]        mul_in1,
  output logic [W2-1:0]        mul_in2,
  input  logic [WO-1:0]        mul_out,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [WO-1:0]        rsp_data,
  output logic [CNT_W-1:0]     inflight,
  output state_e               dbg_state
);

  // Handshake: a transfer happens in any cycle where req_valid[i] & req_ready[i]. req_ready is a
  // combinational function of req_valid, so requesters raise valid without waiting for ready.
  // Responses carry no ready: rsp_valid pulses for one cycle and the requester must take it.

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [W1-1:0]          in1_q, in1_d;
  logic [W2-1:0]          in2_q, in2_d;
  logic [LAT-1:0]         tv_q, tv_d;
  logic [N_REQ-1:0]       tag_q [LAT];
  logic [N_REQ-1:0]       tag_d [LAT];
  logic [CNT_W-1:0]       inflight_q, inflight_d;

  logic                   grant_en;
  logic                   xfer;
  logic                   rsp_fire;
  logic [N_REQ-1:0]       gnt;
  logic [PTR_W-1:0]       gnt_idx;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (grant_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign xfer     = |(req_valid & gnt);
  assign rsp_fire = tv_q[LAT-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (pause) state_d = (inflight_q == '0) ? HALT : DRAIN;
      end
      DRAIN: begin
        if (!pause) state_d = RUN;
        else if (inflight_q == '0) state_d = HALT;
      end
      HALT: begin
        if (!pause) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // A pause seen in the same cycle as a would-be grant already blocks that grant.
  always_comb begin
    grant_en = (state_q == RUN) && !pause && !RST;
    paused   = (state_q == HALT);
  end

  always_comb begin
    ptr_d = ptr_q;
    in1_d = in1_q;
    in2_d = in2_q;
    if (xfer) begin
      in1_d = req_in1[gnt_idx*W1 +: W1];
      in2_d = req_in2[gnt_idx*W2 +: W2];
      ptr_d = (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
    end
    tv_d[0]  = xfer;
    tag_d[0] = gnt;
    for (int s = 1; s < LAT; s++) begin
      tv_d[s]  = tv_q[s-1];
      tag_d[s] = tag_q[s-1];
    end
    inflight_d = inflight_q + CNT_W'(xfer) - CNT_W'(rsp_fire);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q      <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      tv_q       <= '0;
      inflight_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      tv_q       <= tv_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  assign req_ready = gnt;
  assign mul_rst_n = ~RST;
  assign mul_in1   = in1_q;
  assign mul_in2   = in2_q;
  assign rsp_valid = rsp_fire ? tag_q[LAT-1] : '0;
  assign rsp_data  = mul_out;
  assign inflight  = inflight_q;
  assign dbg_state = state_q;

endmodule
